sdram_read_ctrl: RTL and testbench
==================================

// Module: sdram_read_ctrl
// PURPOSE
//  Parametrised SDRAM read sequencer sitting behind the SDRAM arbiter.
//  Reads a programmable number of bursts from a programmable start address and
//  crosses row/bank boundaries automatically. Yields the bus for refresh and
//  resumes afterwards. Returns captured read data with a valid strobe.
// PARAMETERS
//  ROW_W      12  row address width; also the width of rd_addr (must be >= 11)
//  COL_W      9   column address width
//  BANK_W     2   bank address width
//  DATA_W     16  SDRAM data width
//  BURST_LEN  4   beats per RD command (power of 2, 2..8); must match the SDRAM mode register
//  CAS_LAT    3   CAS latency in sclk cycles (2 or 3)
//  T_RCD      3   ACT-to-RD delay in cycles (>= 1)
//  T_RP       3   PRE-to-next-command delay in cycles (>= 1)
// PORTS
//  sclk          in   1                    system clock
//  reset         in   1                    synchronous, active-high reset
//  rd_trig       in   1                    start pulse; sampled only when rd_busy=0
//  rd_start_addr in   BANK_W+ROW_W+COL_W   {bank,row,col}; low log2(BURST_LEN) col bits forced to 0
//  rd_len        in   16                   number of bursts to read; 0 = trigger ignored
//  rd_busy       out  1                    transfer in progress
//  rd_done       out  1                    one-cycle pulse after the last data beat
//  rd_req        out  1                    bus request to arbiter
//  rd_en         in   1                    arbiter grant
//  ref_req       in   1                    refresh pending
//  flag_rd_end   out  1                    one-cycle pulse: bus released
//  rd_cmd        out  4                    {cs_n,ras_n,cas_n,we_n}: NOP 0111, ACT 0011, RD 0101, PRE 0010
//  rd_addr       out  ROW_W                SDRAM A bus
//  bank_addr     out  BANK_W               SDRAM BA bus
//  rd_data       in   DATA_W               SDRAM DQ input
//  rd_dout       out  DATA_W               captured read data
//  rd_dout_vld   out  1                    rd_dout is valid this cycle
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except rd_cmd=NOP. Address regs and the data pipe are cleared.
//   Reset mid-transfer aborts the transfer: in-flight beats are dropped and no rd_done is issued.
//  Outputs: rd_cmd, rd_addr and bank_addr are registered. rd_addr=0 on NOP cycles. rd_req = (state==REQ).
//  FSM states: IDLE, REQ, ACT, RD, PRE.
//  - IDLE: rd_trig=1, rd_busy=0 and rd_len!=0 -> latch address and length; rd_busy=1; go to REQ.
//  - REQ: hold until rd_en=1, then go to ACT. No command is issued while waiting.
//  - ACT: 1st cycle issues ACT with rd_addr=row and bank_addr=bank. Then T_RCD-1 NOPs. Then go to RD.
//  - RD: each burst takes BURST_LEN cycles. The 1st cycle issues RD with rd_addr={0,col} and A10=0;
//    the remaining cycles are NOPs. Bursts run back to back. At the last cycle of each burst:
//    remaining--; col+=BURST_LEN.
//    * Exit priority, evaluated at the last burst cycle: remaining==0 -> PRE(final);
//      else ref_req=1 -> PRE(refresh); else col wrapped to 0 -> PRE(row change).
//    * ref_req arriving mid-burst never truncates the burst.
//  - PRE: 1st cycle issues PRE with A10=1 (all banks). Then T_RP-1 NOPs. Then:
//    * final   -> IDLE, flag_rd_end pulse;
//    * refresh -> REQ, flag_rd_end pulse;
//    * row change -> ACT, bus kept, no flag_rd_end.
//  - Address arithmetic: a col wrap (2^COL_W) increments row. A row wrap increments bank.
//    A bank wrap returns to address 0. All of these are modulo widths.
//  - Data: beat k of the RD issued at cycle t is on rd_data at t+CAS_LAT+k. It is registered to
//    rd_dout with rd_dout_vld=1 at t+CAS_LAT+k+1. Exactly rd_len*BURST_LEN vld beats per transfer,
//    in address order, with no duplicates across refresh or row breaks.
//  - rd_done pulses the cycle after the last vld beat. rd_busy falls in the same cycle.
//    The FSM may already sit in IDLE; rd_trig is still ignored until rd_busy=0.
//  - rd_trig while busy: ignored. Simultaneous rd_en and ref_req in REQ: rd_en wins.
// TESTING (defaults: BL=4, CL=3, T_RCD=3, T_RP=3)
//  1. rd_en tied 1; trig bank0/row5/col0, len=2 -> ACT row5 at cycle X; RD col0 @X+3; RD col4 @X+7;
//     PRE A10=1 @X+11; 8 vld beats @X+7..X+14; one rd_done @X+15.
//  2. Start col=508, len=2 -> RD col508; PRE; ACT row+1 (no flag_rd_end); RD col0; 8 beats in order.
//  3. len=4; ref_req=1 during burst 2 -> burst 2 completes; PRE; flag_rd_end=1; REQ.
//     After rd_en -> ACT same row; RD col8, col12; 16 beats total, none lost or repeated.
//  4. rd_en held 0 for 20 cycles -> rd_req=1 and rd_cmd=NOP throughout; rd_trig pulses ignored.
//  5. Start addr bank3/row4095/col508, len=2 -> wraps to bank0/row0/col0 after the PRE/ACT pair.
//  6. reset=1 mid-RD -> next cycle rd_cmd=NOP, state IDLE, rd_busy=0, no vld or rd_done after. len=0 trig -> no activity.

Source files
------------

// File: rtl/sdram_read_ctrl.sv
// SDRAM read sequencer: issues ACT/RD/PRE bursts over a programmable address range,
// yields the bus for refresh, and returns captured read data with a valid strobe.
module sdram_read_ctrl #(
  parameter int unsigned ROW_W     = 12,
  parameter int unsigned COL_W     = 9,
  parameter int unsigned BANK_W    = 2,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CAS_LAT   = 3,
  parameter int unsigned T_RCD     = 3,
  parameter int unsigned T_RP      = 3
) (
  input  logic                          sclk,
  input  logic                          reset,
  input  logic                          rd_trig,
  input  logic [BANK_W+ROW_W+COL_W-1:0] rd_start_addr,
  input  logic [15:0]                   rd_len,
  output logic                          rd_busy,
  output logic                          rd_done,
  output logic                          rd_req,
  input  logic                          rd_en,
  input  logic                          ref_req,
  output logic                          flag_rd_end,
  output logic [3:0]                    rd_cmd,
  output logic [ROW_W-1:0]              rd_addr,
  output logic [BANK_W-1:0]             bank_addr,
  input  logic [DATA_W-1:0]             rd_data,
  output logic [DATA_W-1:0]             rd_dout,
  output logic                          rd_dout_vld
);

  localparam int unsigned ADDR_W    = BANK_W + ROW_W + COL_W;
  localparam int unsigned BL_LOG    = $clog2(BURST_LEN);
  localparam int unsigned CNT_MAX_A = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > BURST_LEN) ? CNT_MAX_A : BURST_LEN;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX) + 1;
  localparam int unsigned BEATS_W   = 16 + BL_LOG;
  localparam int unsigned HIST_W    = CAS_LAT + BURST_LEN - 1;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACT, S_RD, S_PRE} state_t;
  typedef enum logic [1:0] {PK_FINAL, PK_REFRESH, PK_ROW} pre_kind_t;

  state_t                 state_q, state_d;
  pre_kind_t              kind_q, kind_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [15:0]            remaining_q, remaining_d;
  logic                   flag_d, flag_q;
  logic [3:0]             cmd_d, cmd_q;
  logic [ROW_W-1:0]       a_d, a_q;
  logic [BANK_W-1:0]      ba_d, ba_q;
  logic                   req_d, req_q;
  logic [BEATS_W-1:0]     beats_d, beats_q;
  logic                   busy_d, busy_q;
  logic                   done_d, done_q;
  logic [HIST_W-1:0]      sr_d, sr_q;
  logic [DATA_W-1:0]      dout_d, dout_q;
  logic                   vld_q;
  logic                   start_c;
  logic                   cap_c;

  assign start_c = (state_q == S_IDLE) && rd_trig && !busy_q && (rd_len != 16'd0);

  // FSM state register
  always_ff @(posedge sclk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state, cycle counter and burst address bookkeeping
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    kind_d      = kind_q;
    flag_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          addr_d              = rd_start_addr;
          addr_d[BL_LOG-1:0]  = '0;
          remaining_d         = rd_len;
          state_d             = S_REQ;
        end
      end
      S_REQ: begin
        if (rd_en) begin
          state_d = S_ACT;
          cnt_d   = '0;
        end
      end
      S_ACT: begin
        if (cnt_q == CNT_W'(T_RCD - 1)) begin
          state_d = S_RD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD: begin
        if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
          // Address carry ripples col -> row -> bank -> zero naturally
          addr_d      = addr_q + ADDR_W'(BURST_LEN);
          remaining_d = remaining_q - 16'd1;
          cnt_d       = '0;
          if (remaining_q == 16'd1) begin
            state_d = S_PRE;
            kind_d  = PK_FINAL;
          end else if (ref_req) begin
            state_d = S_PRE;
            kind_d  = PK_REFRESH;
          end else if (addr_d[COL_W-1:0] == '0) begin
            state_d = S_PRE;
            kind_d  = PK_ROW;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PRE: begin
        if (cnt_q == CNT_W'(T_RP - 1)) begin
          cnt_d  = '0;
          flag_d = (kind_q != PK_ROW);
          case (kind_q)
            PK_FINAL:   state_d = S_IDLE;
            PK_REFRESH: state_d = S_REQ;
            default:    state_d = S_ACT;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command/address decode from the upcoming state so registered pins line up with it
  always_comb begin
    cmd_d = CMD_NOP;
    a_d   = '0;
    ba_d  = '0;
    req_d = (state_d == S_REQ);
    if (cnt_d == '0) begin
      case (state_d)
        S_ACT: begin
          cmd_d = CMD_ACT;
          a_d   = addr_d[COL_W +: ROW_W];
          ba_d  = addr_d[COL_W+ROW_W +: BANK_W];
        end
        S_RD: begin
          cmd_d = CMD_RD;
          a_d   = ROW_W'(addr_d[COL_W-1:0]);
          ba_d  = addr_d[COL_W+ROW_W +: BANK_W];
        end
        S_PRE: begin
          cmd_d     = CMD_PRE;
          a_d[10]   = 1'b1;
          ba_d      = addr_d[COL_W+ROW_W +: BANK_W];
        end
        default: ;
      endcase
    end
  end

  // Read-data capture window tracks RD commands through the CAS latency
  always_comb begin
    sr_d    = {sr_q[HIST_W-2:0], (cmd_q == CMD_RD)};
    cap_c   = |sr_q[CAS_LAT+BURST_LEN-2 : CAS_LAT-1];
    dout_d  = cap_c ? rd_data : dout_q;
    done_d  = busy_q && vld_q && (beats_q == '0);
    beats_d = beats_q;
    busy_d  = busy_q;
    if (start_c) begin
      beats_d = BEATS_W'(rd_len) << BL_LOG;
      busy_d  = 1'b1;
    end else begin
      if (cap_c)  beats_d = beats_q - BEATS_W'(1);
      if (done_d) busy_d  = 1'b0;
    end
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      cnt_q       <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      kind_q      <= PK_FINAL;
      flag_q      <= 1'b0;
      cmd_q       <= CMD_NOP;
      a_q         <= '0;
      ba_q        <= '0;
      req_q       <= 1'b0;
      beats_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sr_q        <= '0;
      dout_q      <= '0;
      vld_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      kind_q      <= kind_d;
      flag_q      <= flag_d;
      cmd_q       <= cmd_d;
      a_q         <= a_d;
      ba_q        <= ba_d;
      req_q       <= req_d;
      beats_q     <= beats_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sr_q        <= sr_d;
      dout_q      <= dout_d;
      vld_q       <= cap_c;
    end
  end

  assign rd_busy     = busy_q;
  assign rd_done     = done_q;
  assign rd_req      = req_q;
  assign flag_rd_end = flag_q;
  assign rd_cmd      = cmd_q;
  assign rd_addr     = a_q;
  assign bank_addr   = ba_q;
  assign rd_dout     = dout_q;
  assign rd_dout_vld = vld_q;

endmodule

// File: tb/tb_sdram_read_ctrl.sv
// Bench for sdram_read_ctrl: SDRAM read model plus a beat scoreboard fed in address order.
`timescale 1ns/1ps
module tb_sdram_read_ctrl;

  localparam int unsigned ROW_W  = 12;
  localparam int unsigned COL_W  = 9;
  localparam int unsigned BANK_W = 2;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BL     = 4;
  localparam int unsigned BL_LOG = 2;
  localparam int unsigned CL     = 3;
  localparam int unsigned AW     = BANK_W + ROW_W + COL_W;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] PRE = 4'b0010;

  typedef struct {
    int              cyc;
    logic [3:0]      cmd;
    logic [ROW_W-1:0] addr;
    logic [BANK_W-1:0] ba;
  } ent_t;

  logic              sclk = 1'b0;
  logic              reset = 1'b1;
  logic              rd_trig = 1'b0;
  logic [AW-1:0]     rd_start_addr = '0;
  logic [15:0]       rd_len = '0;
  logic              rd_busy, rd_done, rd_req, flag_rd_end, rd_dout_vld;
  logic              rd_en = 1'b0;
  logic              ref_req = 1'b0;
  logic [3:0]        rd_cmd;
  logic [ROW_W-1:0]  rd_addr;
  logic [BANK_W-1:0] bank_addr;
  logic [DATA_W-1:0] rd_data = '0;
  logic [DATA_W-1:0] rd_dout;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0, flag_cnt = 0, vld_cnt = 0, first_vld_cyc = -1, done_cyc = -1;
  logic [DATA_W-1:0] exp_q[$];
  ent_t cmd_log[$];
  logic [ROW_W-1:0]  open_row [0:3];
  logic [DATA_W-1:0] due_data [0:63];

  sdram_read_ctrl dut (
    .sclk(sclk), .reset(reset), .rd_trig(rd_trig), .rd_start_addr(rd_start_addr),
    .rd_len(rd_len), .rd_busy(rd_busy), .rd_done(rd_done), .rd_req(rd_req),
    .rd_en(rd_en), .ref_req(ref_req), .flag_rd_end(flag_rd_end), .rd_cmd(rd_cmd),
    .rd_addr(rd_addr), .bank_addr(bank_addr), .rd_data(rd_data), .rd_dout(rd_dout),
    .rd_dout_vld(rd_dout_vld)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] beat_data(input logic [AW-1:0] a);
    logic [AW-1:0] m;
    m = a ^ (a >> 7) ^ 23'h2A5A5A;
    return m[DATA_W-1:0];
  endfunction

  function automatic logic [AW-1:0] mk(input int b, input int r, input int c);
    return {BANK_W'(b), ROW_W'(r), COL_W'(c)};
  endfunction

  // SDRAM model, command log and beat scoreboard
  always @(negedge sclk) begin : mon
    logic [AW-1:0] a;
    logic [DATA_W-1:0] e;
    if (rd_cmd != NOP) cmd_log.push_back(ent_t'{cyc, rd_cmd, rd_addr, bank_addr});
    case (rd_cmd)
      ACT: open_row[bank_addr] = rd_addr;
      RD: begin
        total++;
        if (rd_addr[ROW_W-1:COL_W] !== '0) begin
          bad++;
          $display("FAIL rd_upper_addr got=%h want=0", rd_addr[ROW_W-1:COL_W]);
        end
        for (int k = 0; k < int'(BL); k++) begin
          a = {bank_addr, open_row[bank_addr], rd_addr[COL_W-1:0]} + AW'(k);
          due_data[(cyc + int'(CL) + k) % 64] = beat_data(a);
        end
      end
      PRE: begin
        total++;
        if (rd_addr[10] !== 1'b1) begin
          bad++;
          $display("FAIL pre_a10 got=%b want=1", rd_addr[10]);
        end
      end
      default: begin
        total++;
        if (rd_addr !== '0) begin
          bad++;
          $display("FAIL nop_addr got=%h want=0", rd_addr);
        end
      end
    endcase
    if (rd_dout_vld === 1'b1) begin
      total++;
      vld_cnt++;
      if (first_vld_cyc < 0) first_vld_cyc = cyc;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat_extra got=%h want=no beat", rd_dout);
      end else begin
        e = exp_q.pop_front();
        if (rd_dout !== e) begin
          bad++;
          $display("FAIL beat_data got=%h want=%h", rd_dout, e);
        end
      end
    end
    if (rd_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL done_early got=%0d beats pending want=0", exp_q.size());
      end
    end
    if (flag_rd_end === 1'b1) flag_cnt++;
    rd_data = due_data[cyc % 64];
  end

  task automatic step();
    @(negedge sclk);
    #1;
  endtask

  task automatic trig(input logic [AW-1:0] a, input logic [15:0] len, input bit push);
    logic [AW-1:0] base;
    base = a;
    base[BL_LOG-1:0] = '0;
    rd_start_addr = a;
    rd_len = len;
    rd_trig = 1'b1;
    if (push)
      for (int i = 0; i < int'(len) * int'(BL); i++) exp_q.push_back(beat_data(base + AW'(i)));
    step();
    rd_trig = 1'b0;
    step();
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    total++; if (rd_cmd !== NOP)   begin bad++; $display("FAIL reset_cmd got=%b want=%b", rd_cmd, NOP); end
    total++; if (rd_addr !== '0)   begin bad++; $display("FAIL reset_addr got=%h want=0", rd_addr); end
    total++; if (bank_addr !== '0) begin bad++; $display("FAIL reset_bank got=%h want=0", bank_addr); end
    total++; if (rd_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", rd_busy); end
    total++; if (rd_req !== 1'b0)  begin bad++; $display("FAIL reset_req got=%b want=0", rd_req); end
    total++; if (rd_done !== 1'b0 || flag_rd_end !== 1'b0 || rd_dout_vld !== 1'b0) begin
      bad++; $display("FAIL reset_pulses got=%b%b%b want=000", rd_done, flag_rd_end, rd_dout_vld);
    end
    total++; if (rd_dout !== '0)   begin bad++; $display("FAIL reset_dout got=%h want=0", rd_dout); end
  endtask

  task automatic test_basic();
    logic [3:0] ec [4] = '{ACT, RD, RD, PRE};
    logic [ROW_W-1:0] ea [4] = '{12'd5, 12'd0, 12'd4, 12'h400};
    int eo [4] = '{0, 3, 7, 11};
    int x, d0, f0;
    bit ok;
    rd_en = 1'b1;
    cmd_log.delete();
    first_vld_cyc = -1;
    d0 = done_cnt; f0 = flag_cnt;
    vld_cnt = 0;
    trig(mk(0, 5, 0), 16'd2, 1'b1);
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_done got=none want=pulse"); end
    total++; if (rd_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b want=0", rd_busy); end
    repeat (6) step();
    total++; if (cmd_log.size() != 4) begin bad++; $display("FAIL basic_ncmd got=%0d want=4", cmd_log.size()); end
    x = (cmd_log.size() > 0) ? cmd_log[0].cyc : 0;
    for (int i = 0; i < 4 && i < cmd_log.size(); i++) begin
      total++;
      if (cmd_log[i].cmd !== ec[i] || cmd_log[i].addr !== ea[i] || cmd_log[i].cyc - x != eo[i]) begin
        bad++;
        $display("FAIL basic_cmd%0d got=%b/%h@%0d want=%b/%h@%0d", i, cmd_log[i].cmd,
                 cmd_log[i].addr, cmd_log[i].cyc - x, ec[i], ea[i], eo[i]);
      end
    end
    total++; if (first_vld_cyc - x != 7) begin bad++; $display("FAIL basic_first_vld got=%0d want=7", first_vld_cyc - x); end
    total++; if (done_cyc - x != 15) begin bad++; $display("FAIL basic_done_cyc got=%0d want=15", done_cyc - x); end
    total++; if (vld_cnt != 8) begin bad++; $display("FAIL basic_beats got=%0d want=8", vld_cnt); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL basic_ndone got=%0d want=1", done_cnt - d0); end
    total++; if (flag_cnt - f0 != 1) begin bad++; $display("FAIL basic_flag got=%0d want=1", flag_cnt - f0); end
  endtask

  task automatic test_row_cross();
    logic [3:0] ec [6] = '{ACT, RD, PRE, ACT, RD, PRE};
    logic [ROW_W-1:0] ea [6] = '{12'd10, 12'h1FC, 12'h400, 12'd11, 12'd0, 12'h400};
    int f0;
    bit ok;
    cmd_log.delete();
    f0 = flag_cnt;
    vld_cnt = 0;
    trig(mk(1, 10, 508), 16'd2, 1'b1);
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL rowx_done got=none want=pulse"); end
    repeat (6) step();
    total++; if (cmd_log.size() != 6) begin bad++; $display("FAIL rowx_ncmd got=%0d want=6", cmd_log.size()); end
    for (int i = 0; i < 6 && i < cmd_log.size(); i++) begin
      total++;
      if (cmd_log[i].cmd !== ec[i] || cmd_log[i].addr !== ea[i] || (ec[i] != PRE && cmd_log[i].ba !== 2'd1)) begin
        bad++;
        $display("FAIL rowx_cmd%0d got=%b/%h/%0d want=%b/%h/1", i, cmd_log[i].cmd, cmd_log[i].addr,
                 cmd_log[i].ba, ec[i], ea[i]);
      end
    end
    total++; if (flag_cnt - f0 != 1) begin bad++; $display("FAIL rowx_flag got=%0d want=1", flag_cnt - f0); end
    total++; if (vld_cnt != 8) begin bad++; $display("FAIL rowx_beats got=%0d want=8", vld_cnt); end
  endtask

  task automatic test_refresh();
    logic [3:0] ec [8] = '{ACT, RD, RD, PRE, ACT, RD, RD, PRE};
    logic [ROW_W-1:0] ea [8] = '{12'd7, 12'd0, 12'd4, 12'h400, 12'd7, 12'd8, 12'd12, 12'h400};
    int nrd, f0;
    bit ok;
    cmd_log.delete();
    f0 = flag_cnt;
    vld_cnt = 0;
    trig(mk(2, 7, 0), 16'd4, 1'b1);
    nrd = 0;
    for (int i = 0; i < 100 && nrd < 2; i++) begin
      nrd = 0;
      foreach (cmd_log[j]) if (cmd_log[j].cmd == RD) nrd++;
      if (nrd < 2) step();
    end
    total++; if (nrd != 2) begin bad++; $display("FAIL ref_second_rd got=%0d want=2", nrd); end
    ref_req = 1'b1;
    rd_en = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      step();
      if (flag_cnt != f0) ok = 1'b1;
    end
    ref_req = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL ref_flag got=none want=pulse"); end
    repeat (3) begin
      total++;
      if (rd_req !== 1'b1 || rd_cmd !== NOP) begin
        bad++; $display("FAIL ref_wait_req got=%b/%b want=1/%b", rd_req, rd_cmd, NOP);
      end
      step();
    end
    rd_en = 1'b1;
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL ref_done got=none want=pulse"); end
    repeat (6) step();
    total++; if (cmd_log.size() != 8) begin bad++; $display("FAIL ref_ncmd got=%0d want=8", cmd_log.size()); end
    for (int i = 0; i < 8 && i < cmd_log.size(); i++) begin
      total++;
      if (cmd_log[i].cmd !== ec[i] || cmd_log[i].addr !== ea[i]) begin
        bad++;
        $display("FAIL ref_cmd%0d got=%b/%h want=%b/%h", i, cmd_log[i].cmd, cmd_log[i].addr, ec[i], ea[i]);
      end
    end
    if (cmd_log.size() >= 4) begin
      total++;
      if (cmd_log[3].cyc - cmd_log[2].cyc != int'(BL)) begin
        bad++; $display("FAIL ref_burst_len got=%0d want=%0d", cmd_log[3].cyc - cmd_log[2].cyc, BL);
      end
    end
    total++; if (vld_cnt != 16) begin bad++; $display("FAIL ref_beats got=%0d want=16", vld_cnt); end
    total++; if (flag_cnt - f0 != 2) begin bad++; $display("FAIL ref_nflag got=%0d want=2", flag_cnt - f0); end
  endtask

  task automatic test_hold();
    logic [3:0] ec [3] = '{ACT, RD, PRE};
    logic [ROW_W-1:0] ea [3] = '{12'd20, 12'd0, 12'h400};
    bit ok;
    rd_en = 1'b0;
    cmd_log.delete();
    vld_cnt = 0;
    trig(mk(0, 20, 2), 16'd1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      total++;
      if (rd_req !== 1'b1 || rd_cmd !== NOP || rd_busy !== 1'b1) begin
        bad++; $display("FAIL hold_cycle%0d got=req%b/cmd%b/busy%b want=1/%b/1", i, rd_req, rd_cmd, rd_busy, NOP);
      end
      rd_trig = (i == 5 || i == 11);
      rd_start_addr = mk(3, 99, 0);
      rd_len = 16'd3;
      step();
    end
    rd_trig = 1'b0;
    rd_en = 1'b1;
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL hold_done got=none want=pulse"); end
    repeat (20) step();
    total++; if (cmd_log.size() != 3) begin bad++; $display("FAIL hold_ncmd got=%0d want=3", cmd_log.size()); end
    for (int i = 0; i < 3 && i < cmd_log.size(); i++) begin
      total++;
      if (cmd_log[i].cmd !== ec[i] || cmd_log[i].addr !== ea[i]) begin
        bad++; $display("FAIL hold_cmd%0d got=%b/%h want=%b/%h", i, cmd_log[i].cmd, cmd_log[i].addr, ec[i], ea[i]);
      end
    end
    total++; if (vld_cnt != 4) begin bad++; $display("FAIL hold_beats got=%0d want=4", vld_cnt); end
  endtask

  task automatic test_wrap();
    logic [3:0] ec [6] = '{ACT, RD, PRE, ACT, RD, PRE};
    logic [ROW_W-1:0] ea [6] = '{12'hFFF, 12'h1FC, 12'h400, 12'd0, 12'd0, 12'h400};
    logic [BANK_W-1:0] eb [6] = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    bit ok;
    cmd_log.delete();
    vld_cnt = 0;
    trig(mk(3, 4095, 508), 16'd2, 1'b1);
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_done got=none want=pulse"); end
    repeat (6) step();
    total++; if (cmd_log.size() != 6) begin bad++; $display("FAIL wrap_ncmd got=%0d want=6", cmd_log.size()); end
    for (int i = 0; i < 6 && i < cmd_log.size(); i++) begin
      total++;
      if (cmd_log[i].cmd !== ec[i] || cmd_log[i].addr !== ea[i] || (ec[i] != PRE && cmd_log[i].ba !== eb[i])) begin
        bad++;
        $display("FAIL wrap_cmd%0d got=%b/%h/%0d want=%b/%h/%0d", i, cmd_log[i].cmd, cmd_log[i].addr,
                 cmd_log[i].ba, ec[i], ea[i], eb[i]);
      end
    end
    total++; if (vld_cnt != 8) begin bad++; $display("FAIL wrap_beats got=%0d want=8", vld_cnt); end
  endtask

  task automatic test_reset_mid();
    int d0, v0, nrd;
    cmd_log.delete();
    trig(mk(1, 3, 0), 16'd4, 1'b1);
    nrd = 0;
    for (int i = 0; i < 50 && nrd == 0; i++) begin
      foreach (cmd_log[j]) if (cmd_log[j].cmd == RD) nrd++;
      if (nrd == 0) step();
    end
    total++; if (nrd == 0) begin bad++; $display("FAIL rstmid_rd got=none want=RD"); end
    repeat (2) step();
    reset = 1'b1;
    exp_q.delete();
    step();
    reset = 1'b0;
    total++; if (rd_cmd !== NOP) begin bad++; $display("FAIL rstmid_cmd got=%b want=%b", rd_cmd, NOP); end
    total++; if (rd_busy !== 1'b0 || rd_req !== 1'b0) begin
      bad++; $display("FAIL rstmid_busy got=%b/%b want=0/0", rd_busy, rd_req);
    end
    d0 = done_cnt; v0 = vld_cnt;
    cmd_log.delete();
    repeat (30) step();
    total++; if (vld_cnt != v0) begin bad++; $display("FAIL rstmid_vld got=%0d want=0", vld_cnt - v0); end
    total++; if (done_cnt != d0) begin bad++; $display("FAIL rstmid_done got=%0d want=0", done_cnt - d0); end
    total++; if (cmd_log.size() != 0) begin bad++; $display("FAIL rstmid_cmds got=%0d want=0", cmd_log.size()); end
    trig(mk(2, 50, 0), 16'd0, 1'b0);
    repeat (10) step();
    total++; if (rd_busy !== 1'b0 || rd_req !== 1'b0) begin
      bad++; $display("FAIL len0_busy got=%b/%b want=0/0", rd_busy, rd_req);
    end
    total++; if (cmd_log.size() != 0) begin bad++; $display("FAIL len0_cmds got=%0d want=0", cmd_log.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (3) step();
    test_reset();
    reset = 1'b0;
    step();
    test_basic();
    test_row_cross();
    test_refresh();
    test_hold();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
